// File: rtl/traffic_seq_if.sv
// rtl/traffic_seq_if.sv - sequencer <-> external 4-bit up/down counter bus
// Purpose: groups the control and state signals exchanged with the counter.
// Signals:
//   cnt_q      counter state (counter -> sequencer)
//   cnt_clr_n  counter clear, active-low
//   cnt_ld_n   counter synchronous load, active-low
//   cnt_m      counter direction (1 up, 0 down)
//   cnt_a      counter load data
// Modports: master = sequencer side, slave = counter side.
interface traffic_seq_if;
  logic [3:0] cnt_q;
  logic       cnt_clr_n;
  logic       cnt_ld_n;
  logic       cnt_m;
  logic [3:0] cnt_a;

  modport master (
    input  cnt_q,
    output cnt_clr_n,
    output cnt_ld_n,
    output cnt_m,
    output cnt_a
  );

  modport slave (
    output cnt_q,
    input  cnt_clr_n,
    input  cnt_ld_n,
    input  cnt_m,
    input  cnt_a
  );
endinterface

// File: rtl/traffic_seq.sv
// rtl/traffic_seq.sv - traffic-light phase sequencer driving an external counter
// Purpose: loads each phase duration into the external counter, lets it count
//   down, and advances RED -> GREEN -> YELLOW -> RED. Supports pause (en=0) and
//   pedestrian requests that shorten green.
// Ports:
//   cp       clock, rising edge
//   clr      synchronous reset, active-high
//   en       run enable; 0 freezes phase and count
//   ped_req  pedestrian request, sampled every cycle
//   cnt      counter bus (traffic_seq_if.master)
//   red/yellow/green  lamps, exactly one on
//   phase    00 red, 01 green, 10 yellow
//   ped_ack  one-cycle registered pulse when a request is served
module traffic_seq #(
  parameter logic [3:0] R_TIME  = 4'd9,
  parameter logic [3:0] G_TIME  = 4'd12,
  parameter logic [3:0] Y_TIME  = 4'd2,
  parameter logic [3:0] PED_MIN = 4'd3
) (
  input  logic                 cp,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 ped_req,
  traffic_seq_if.master        cnt,
  output logic                 red,
  output logic                 yellow,
  output logic                 green,
  output logic [1:0]           phase,
  output logic                 ped_ack
);

  typedef enum logic [2:0] {
    RLD = 3'd0,
    RED = 3'd1,
    GLD = 3'd2,
    GRN = 3'd3,
    YLD = 3'd4,
    YEL = 3'd5
  } state_t;

  state_t state;
  state_t state_next;
  logic   ped_pend;
  logic   pend_next;
  logic   serve;

  always_ff @(posedge cp) begin
    if (clr) begin
      state    <= RLD;
      ped_pend <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      state    <= state_next;
      ped_pend <= pend_next;
      ped_ack  <= serve;
    end
  end

  always_comb begin
    state_next    = state;
    serve         = 1'b0;
    cnt.cnt_clr_n = 1'b1;
    cnt.cnt_ld_n  = 1'b1;
    cnt.cnt_m     = 1'b0;
    cnt.cnt_a     = 4'd0;

    if (clr) begin
      cnt.cnt_clr_n = 1'b0;
    end else begin
      case (state)
        RLD: begin
          cnt.cnt_ld_n = 1'b0;
          cnt.cnt_a    = R_TIME;
          if (en) state_next = RED;
        end
        GLD: begin
          cnt.cnt_ld_n = 1'b0;
          cnt.cnt_a    = G_TIME;
          if (en) state_next = GRN;
        end
        YLD: begin
          cnt.cnt_ld_n = 1'b0;
          cnt.cnt_a    = Y_TIME;
          if (en) state_next = YEL;
        end
        RED, YEL: begin
          if (!en) begin
            // Reloading the current value is how the counter is held still.
            cnt.cnt_ld_n = 1'b0;
            cnt.cnt_a    = cnt.cnt_q;
          end else if (cnt.cnt_q == 4'd0) begin
            state_next = (state == RED) ? GLD : RLD;
          end
        end
        GRN: begin
          if (!en) begin
            cnt.cnt_ld_n = 1'b0;
            cnt.cnt_a    = cnt.cnt_q;
          end else begin
            // A request arriving this very cycle is served without waiting.
            serve = ped_pend | ped_req;
            if (cnt.cnt_q == 4'd0) begin
              state_next = YLD;
            end else if (serve && (cnt.cnt_q > PED_MIN)) begin
              cnt.cnt_ld_n = 1'b0;
              cnt.cnt_a    = PED_MIN;
            end
          end
        end
        default: state_next = RLD;
      endcase
    end
  end

  // Serving clears the pending flag even if ped_req is still asserted;
  // a held request re-arms on the following cycle.
  always_comb begin
    pend_next = ped_pend | ped_req;
    if (serve) pend_next = 1'b0;
  end

  always_comb begin
    red    = 1'b0;
    yellow = 1'b0;
    green  = 1'b0;
    phase  = 2'b00;
    case (state)
      GLD, GRN: begin
        green = 1'b1;
        phase = 2'b01;
      end
      YLD, YEL: begin
        yellow = 1'b1;
        phase  = 2'b10;
      end
      default: red = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_traffic_seq.sv
// tb/tb_traffic_seq.sv - directed self-checking bench for traffic_seq
module tb_traffic_seq;
  logic       cp = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic       ped_req = 1'b0;
  logic       red, yellow, green, ped_ack;
  logic [1:0] phase;
  int         total = 0;
  int         bad = 0;

  traffic_seq_if bus ();

  traffic_seq dut (
    .cp      (cp),
    .clr     (clr),
    .en      (en),
    .ped_req (ped_req),
    .cnt     (bus),
    .red     (red),
    .yellow  (yellow),
    .green   (green),
    .phase   (phase),
    .ped_ack (ped_ack)
  );

  always #5 cp = ~cp;

  // External counter model.
  always @(posedge cp) begin
    if (!bus.cnt_clr_n)     bus.cnt_q <= 4'd0;
    else if (!bus.cnt_ld_n) bus.cnt_q <= bus.cnt_a;
    else if (bus.cnt_m)     bus.cnt_q <= bus.cnt_q + 4'd1;
    else                    bus.cnt_q <= bus.cnt_q - 4'd1;
  end

  // One clock cycle: drive inputs after the edge, return at the falling edge.
  task automatic cyc(input logic c, input logic e, input logic p);
    @(posedge cp);
    #1;
    clr = c; en = e; ped_req = p;
    @(negedge cp);
  endtask

  // Two reset cycles, then return positioned before cycle k=0 (RLD).
  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.cnt_clr_n !== 1'b0) begin bad++; $display("FAIL rst_clr_n got=%0b exp=0", bus.cnt_clr_n); end
    total++; if (bus.cnt_ld_n !== 1'b1) begin bad++; $display("FAIL rst_ld_n got=%0b exp=1", bus.cnt_ld_n); end
    total++; if ({red, yellow, green} !== 3'b100) begin bad++; $display("FAIL rst_lamps got=%b exp=100", {red, yellow, green}); end
    total++; if (phase !== 2'b00) begin bad++; $display("FAIL rst_phase got=%b exp=00", phase); end
    total++; if (ped_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%0b exp=0", ped_ack); end
    total++; if (bus.cnt_q !== 4'd0) begin bad++; $display("FAIL rst_cnt_q got=%0d exp=0", bus.cnt_q); end
    total++; if (bus.cnt_m !== 1'b0) begin bad++; $display("FAIL rst_m got=%0b exp=0", bus.cnt_m); end
    cyc(1'b0, 1'b0, 1'b0);
    total++; if (bus.cnt_clr_n !== 1'b1) begin bad++; $display("FAIL rld_clr_n got=%0b exp=1", bus.cnt_clr_n); end
    total++; if (bus.cnt_ld_n !== 1'b0 || bus.cnt_a !== 4'd9) begin bad++; $display("FAIL rld_load got ld_n=%0b a=%0d exp ld_n=0 a=9", bus.cnt_ld_n, bus.cnt_a); end
  endtask

  task automatic test_normal();
    logic [1:0] ep;
    logic       eld;
    int         lows;
    do_reset();
    lows = 0;
    for (int k = 0; k <= 29; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      ep  = (k < 11) ? 2'd0 : (k < 25) ? 2'd1 : (k < 29) ? 2'd2 : 2'd0;
      eld = !(k == 0 || k == 11 || k == 25 || k == 29);
      if (!bus.cnt_ld_n) lows++;
      total++; if (phase !== ep) begin bad++; $display("FAIL norm_phase k=%0d got=%0d exp=%0d", k, phase, ep); end
      total++; if (bus.cnt_ld_n !== eld) begin bad++; $display("FAIL norm_ld_n k=%0d got=%0b exp=%0b", k, bus.cnt_ld_n, eld); end
      total++; if ({red, yellow, green} !== {ep == 2'd0, ep == 2'd2, ep == 2'd1}) begin bad++; $display("FAIL norm_lamps k=%0d got=%b", k, {red, yellow, green}); end
      if (k == 1) begin total++; if (bus.cnt_q !== 4'd9) begin bad++; $display("FAIL norm_red_first got=%0d exp=9", bus.cnt_q); end end
      if (k == 10) begin total++; if (bus.cnt_q !== 4'd0) begin bad++; $display("FAIL norm_red_last got=%0d exp=0", bus.cnt_q); end end
      if (k == 12) begin total++; if (bus.cnt_q !== 4'd12) begin bad++; $display("FAIL norm_grn_first got=%0d exp=12", bus.cnt_q); end end
      if (k == 26) begin total++; if (bus.cnt_q !== 4'd2) begin bad++; $display("FAIL norm_yel_first got=%0d exp=2", bus.cnt_q); end end
    end
    total++; if (lows !== 4) begin bad++; $display("FAIL norm_load_count got=%0d exp=4", lows); end
  endtask

  task automatic test_ped_shorten();
    do_reset();
    for (int k = 0; k <= 13; k++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1); // k=14, GRN cnt_q=10
    total++; if (bus.cnt_q !== 4'd10 || phase !== 2'd1) begin bad++; $display("FAIL shr_pos got q=%0d ph=%0d exp q=10 ph=1", bus.cnt_q, phase); end
    total++; if (bus.cnt_ld_n !== 1'b0 || bus.cnt_a !== 4'd3) begin bad++; $display("FAIL shr_load got ld_n=%0b a=%0d exp ld_n=0 a=3", bus.cnt_ld_n, bus.cnt_a); end
    total++; if (ped_ack !== 1'b0) begin bad++; $display("FAIL shr_ack_early got=%0b exp=0", ped_ack); end
    cyc(1'b0, 1'b1, 1'b0); // k=15
    total++; if (bus.cnt_q !== 4'd3 || ped_ack !== 1'b1) begin bad++; $display("FAIL shr_k15 got q=%0d ack=%0b exp q=3 ack=1", bus.cnt_q, ped_ack); end
    total++; if (bus.cnt_ld_n !== 1'b1) begin bad++; $display("FAIL shr_k15_ld got=%0b exp=1", bus.cnt_ld_n); end
    cyc(1'b0, 1'b1, 1'b0); // k=16
    total++; if (bus.cnt_q !== 4'd2 || ped_ack !== 1'b0) begin bad++; $display("FAIL shr_k16 got q=%0d ack=%0b exp q=2 ack=0", bus.cnt_q, ped_ack); end
    cyc(1'b0, 1'b1, 1'b0); // k=17
    cyc(1'b0, 1'b1, 1'b0); // k=18
    total++; if (bus.cnt_q !== 4'd0 || phase !== 2'd1) begin bad++; $display("FAIL shr_k18 got q=%0d ph=%0d exp q=0 ph=1", bus.cnt_q, phase); end
    cyc(1'b0, 1'b1, 1'b0); // k=19
    total++; if (phase !== 2'd2 || bus.cnt_ld_n !== 1'b0 || bus.cnt_a !== 4'd2) begin bad++; $display("FAIL shr_yld got ph=%0d ld_n=%0b a=%0d exp ph=2 ld_n=0 a=2", phase, bus.cnt_ld_n, bus.cnt_a); end
  endtask

  task automatic test_ped_late();
    do_reset();
    for (int k = 0; k <= 21; k++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1); // k=22, cnt_q=2
    total++; if (bus.cnt_q !== 4'd2 || bus.cnt_ld_n !== 1'b1) begin bad++; $display("FAIL late_noload got q=%0d ld_n=%0b exp q=2 ld_n=1", bus.cnt_q, bus.cnt_ld_n); end
    cyc(1'b0, 1'b1, 1'b0); // k=23
    total++; if (ped_ack !== 1'b1 || bus.cnt_q !== 4'd1) begin bad++; $display("FAIL late_ack got ack=%0b q=%0d exp ack=1 q=1", ped_ack, bus.cnt_q); end
    cyc(1'b0, 1'b1, 1'b0); // k=24
    total++; if (ped_ack !== 1'b0 || phase !== 2'd1) begin bad++; $display("FAIL late_k24 got ack=%0b ph=%0d exp ack=0 ph=1", ped_ack, phase); end
    cyc(1'b0, 1'b1, 1'b0); // k=25
    total++; if (phase !== 2'd2) begin bad++; $display("FAIL late_len got ph=%0d exp=2", phase); end

    // Request held high from cnt_q=4 to the end of green.
    do_reset();
    for (int k = 0; k <= 19; k++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1); // k=20, cnt_q=4
    total++; if (bus.cnt_ld_n !== 1'b0 || bus.cnt_a !== 4'd3) begin bad++; $display("FAIL hold_load got ld_n=%0b a=%0d exp ld_n=0 a=3", bus.cnt_ld_n, bus.cnt_a); end
    cyc(1'b0, 1'b1, 1'b1); // k=21, cnt_q=3
    total++; if (ped_ack !== 1'b1 || bus.cnt_q !== 4'd3 || bus.cnt_ld_n !== 1'b1) begin bad++; $display("FAIL hold_k21 got ack=%0b q=%0d ld_n=%0b exp 1 3 1", ped_ack, bus.cnt_q, bus.cnt_ld_n); end
    cyc(1'b0, 1'b1, 1'b1); // k=22
    cyc(1'b0, 1'b1, 1'b1); // k=23
    cyc(1'b0, 1'b1, 1'b1); // k=24, cnt_q=0
    total++; if (ped_ack !== 1'b1 || bus.cnt_q !== 4'd0) begin bad++; $display("FAIL hold_k24 got ack=%0b q=%0d exp ack=1 q=0", ped_ack, bus.cnt_q); end
    cyc(1'b0, 1'b1, 1'b0); // k=25, YLD
    total++; if (ped_ack !== 1'b1 || phase !== 2'd2) begin bad++; $display("FAIL hold_k25 got ack=%0b ph=%0d exp ack=1 ph=2", ped_ack, phase); end
    cyc(1'b0, 1'b1, 1'b0); // k=26
    total++; if (ped_ack !== 1'b0) begin bad++; $display("FAIL hold_k26 got ack=%0b exp=0", ped_ack); end
  endtask

  task automatic test_ped_red();
    do_reset();
    for (int k = 0; k <= 4; k++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1); // k=5, RED cnt_q=5
    total++; if (bus.cnt_q !== 4'd5) begin bad++; $display("FAIL red_pos got=%0d exp=5", bus.cnt_q); end
    for (int k = 6; k <= 11; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      total++; if (ped_ack !== 1'b0) begin bad++; $display("FAIL red_noack k=%0d got=%0b exp=0", k, ped_ack); end
    end
    cyc(1'b0, 1'b1, 1'b0); // k=12, first GRN cycle
    total++; if (bus.cnt_q !== 4'd12 || bus.cnt_ld_n !== 1'b0 || bus.cnt_a !== 4'd3) begin bad++; $display("FAIL red_serve got q=%0d ld_n=%0b a=%0d exp 12 0 3", bus.cnt_q, bus.cnt_ld_n, bus.cnt_a); end
    cyc(1'b0, 1'b1, 1'b0); // k=13
    total++; if (ped_ack !== 1'b1 || bus.cnt_q !== 4'd3) begin bad++; $display("FAIL red_ack got ack=%0b q=%0d exp ack=1 q=3", ped_ack, bus.cnt_q); end
    cyc(1'b0, 1'b1, 1'b0); // k=14
    total++; if (ped_ack !== 1'b0) begin bad++; $display("FAIL red_ack_once got=%0b exp=0", ped_ack); end
    cyc(1'b0, 1'b1, 1'b0); // k=15
    cyc(1'b0, 1'b1, 1'b0); // k=16, cnt_q=0
    total++; if (phase !== 2'd1 || bus.cnt_q !== 4'd0) begin bad++; $display("FAIL red_grn_end got ph=%0d q=%0d exp ph=1 q=0", phase, bus.cnt_q); end
    cyc(1'b0, 1'b1, 1'b0); // k=17
    total++; if (phase !== 2'd2) begin bad++; $display("FAIL red_grn_len got ph=%0d exp=2", phase); end
  endtask

  task automatic test_pause();
    do_reset();
    for (int k = 0; k <= 3; k++) cyc(1'b0, 1'b1, 1'b0);
    for (int k = 4; k <= 8; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      total++; if (bus.cnt_q !== 4'd6 || bus.cnt_ld_n !== 1'b0 || bus.cnt_a !== 4'd6) begin bad++; $display("FAIL pause_hold k=%0d got q=%0d ld_n=%0b a=%0d exp 6 0 6", k, bus.cnt_q, bus.cnt_ld_n, bus.cnt_a); end
      total++; if ({red, yellow, green} !== 3'b100) begin bad++; $display("FAIL pause_lamps k=%0d got=%b exp=100", k, {red, yellow, green}); end
    end
    for (int k = 9; k <= 15; k++) cyc(1'b0, 1'b1, 1'b0);
    total++; if (phase !== 2'd0 || bus.cnt_q !== 4'd0) begin bad++; $display("FAIL pause_red_end got ph=%0d q=%0d exp ph=0 q=0", phase, bus.cnt_q); end
    cyc(1'b0, 1'b0, 1'b0); // k=16, GLD paused
    total++; if (phase !== 2'd1 || bus.cnt_ld_n !== 1'b0 || bus.cnt_a !== 4'd12) begin bad++; $display("FAIL pause_gld got ph=%0d ld_n=%0b a=%0d exp 1 0 12", phase, bus.cnt_ld_n, bus.cnt_a); end
    cyc(1'b0, 1'b0, 1'b0); // k=17
    total++; if (bus.cnt_ld_n !== 1'b0 || bus.cnt_a !== 4'd12 || bus.cnt_q !== 4'd12) begin bad++; $display("FAIL pause_gld_rep got ld_n=%0b a=%0d q=%0d exp 0 12 12", bus.cnt_ld_n, bus.cnt_a, bus.cnt_q); end
    cyc(1'b0, 1'b1, 1'b0); // k=18, still GLD
    total++; if (bus.cnt_ld_n !== 1'b0) begin bad++; $display("FAIL pause_gld_run got ld_n=%0b exp=0", bus.cnt_ld_n); end
    cyc(1'b0, 1'b1, 1'b0); // k=19, GRN
    total++; if (bus.cnt_ld_n !== 1'b1 || bus.cnt_q !== 4'd12 || phase !== 2'd1) begin bad++; $display("FAIL pause_grn got ld_n=%0b q=%0d ph=%0d exp 1 12 1", bus.cnt_ld_n, bus.cnt_q, phase); end
  endtask

  task automatic test_clr_mid();
    int acks;
    do_reset();
    for (int k = 0; k <= 25; k++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1); // k=26, YEL cnt_q=2, request latched
    cyc(1'b1, 1'b1, 1'b0); // k=27, YEL cnt_q=1, clr asserted
    total++; if (bus.cnt_q !== 4'd1 || bus.cnt_clr_n !== 1'b0 || bus.cnt_ld_n !== 1'b1) begin bad++; $display("FAIL clr_mid got q=%0d clr_n=%0b ld_n=%0b exp 1 0 1", bus.cnt_q, bus.cnt_clr_n, bus.cnt_ld_n); end
    cyc(1'b0, 1'b1, 1'b0); // RLD
    total++; if ({red, yellow, green} !== 3'b100 || phase !== 2'd0 || bus.cnt_q !== 4'd0) begin bad++; $display("FAIL clr_after got lamps=%b ph=%0d q=%0d exp 100 0 0", {red, yellow, green}, phase, bus.cnt_q); end
    acks = 0;
    for (int k = 1; k <= 26; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (ped_ack) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL clr_no_ack got=%0d exp=0", acks); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_ped_shorten();
    test_ped_late();
    test_ped_red();
    test_pause();
    test_clr_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_seq.md
Name: traffic_seq

Overview:
- Traffic-light phase sequencer that drives an external 4-bit loadable up/down counter.
- The counter has these controls: active-low clear, active-low synchronous load, direction bit `m` (1 = up, 0 = down), load data, and a state output.
- This block loads the per-phase duration, counts it down, and advances RED -> GREEN -> YELLOW -> RED.
- It also supports pause and pedestrian-request green shortening.

Parameters:
- R_TIME, 4'd9: counter load value for red; red phase = R_TIME+2 cycles.
- G_TIME, 4'd12: counter load value for green; green phase = G_TIME+2 cycles.
- Y_TIME, 4'd2: counter load value for yellow; yellow phase = Y_TIME+2 cycles.
- PED_MIN, 4'd3: remaining-count value green is cut to on a pedestrian request; must be < G_TIME.

Ports:
- cp  in  1  clock; all state changes on rising edge.
- clr  in  1  synchronous reset, active-high.
- en  in  1  run enable; 0 = pause (freeze phase and count).
- ped_req  in  1  pedestrian request; level or pulse, sampled every cycle.
- cnt_q  in  4  counter state output.
- cnt_clr_n  out  1  counter clear, active-low.
- cnt_ld_n  out  1  counter load, active-low.
- cnt_m  out  1  counter direction; always 0 (down).
- cnt_a  out  4  counter load data.
- red  out  1  red lamp.
- yellow  out  1  yellow lamp.
- green  out  1  green lamp.
- phase  out  2  00 red, 01 green, 10 yellow; 11 never driven.
- ped_ack  out  1  one-cycle registered pulse; request served.

Behaviour:
- Reset: reset is synchronous and active-high via `clr`, on the single clock `cp`.
  - While clr=1: cnt_clr_n=0 combinationally, cnt_ld_n=1.
  - On the clr edge: state <= RLD, ped_pend <= 0, ped_ack <= 0.
  - After reset: red=1, yellow=0, green=0, phase=00.
  - Otherwise cnt_clr_n=1 and cnt_m=0 at all times.
- States: RLD, RED, GLD, GRN, YLD, YEL.
  - Lamps and phase decode from state: xLD and its run state share one lamp.
  - Exactly one lamp is on.
- Load states (xLD):
  - cnt_ld_n=0, cnt_a = the phase time parameter.
  - Next state = run state if en=1; otherwise stay in xLD (repeat load).
- Run states (RED/GRN/YEL):
  - cnt_ld_n=1, counter decrements each cycle.
  - When cnt_q==0 and en=1: next state = next phase load state (RED->GLD, GRN->YLD, YEL->RLD).
  - A run state therefore observes cnt_q = T, T-1, ..., 0, i.e. T+1 cycles; phase total = T+2 cycles.
- Pause, en=0 in a run state:
  - cnt_ld_n=0, cnt_a=cnt_q (reload current value = hold).
  - State holds; no transition even if cnt_q==0.
  - ped_req is still latched, but not served.
- Pedestrian handling:
  - ped_pend is set by ped_req=1 in any state except during clr.
  - Service condition: state GRN with en=1 and ped_pend=1 (pend from earlier cycles, or ped_req this cycle).
  - If cnt_q > PED_MIN and cnt_q != 0: cnt_ld_n=0, cnt_a=PED_MIN.
  - Otherwise: no load (green is already short enough).
  - In both cases: ped_pend <= 0 and ped_ack <= 1 on the next cycle only.
  - A request during RED or YELLOW is held and served on the first enabled GRN cycle.
- Priority, per cycle: clr > en=0 hold > cnt_q==0 transition > pedestrian shorten.
  - A service coinciding with cnt_q==0 in GRN still acks and clears ped_pend, and moves to YLD without a load.
- Counter wrap: the block never lets the counter pass 0 downward, because the transition occurs on cnt_q==0.
  - The counter's wrap/carry output is not used.
- The unused state encoding recovers to RLD on the next edge.

Test Plan:
- Reset then en=1, ped_req=0, defaults -> red 11 cycles (cnt_q 9..0 in RED), green 14, yellow 4; red again at cycle 29; cnt_ld_n low exactly 1 cycle per phase.
- ped_req pulse in GRN at cnt_q=10 -> same cycle cnt_ld_n=0 with cnt_a=3; cnt_q 3,2,1,0; then YLD; ped_ack high 1 cycle, 1 cycle after the request.
- ped_req in GRN at cnt_q=2 -> no load, green length unchanged (14), ped_ack pulses once; a second ped_req held high for the rest of green -> ack repeats one cycle after each service.
- ped_req during RED at cnt_q=5 -> no ack in red; in first GRN cycle cnt_q=12 > 3 -> load 3, ack; green lasts 1+1+4 = 6 cycles.
- en=0 for 5 cycles in RED at cnt_q=6 -> cnt_q stays 6, cnt_a=6, lamps unchanged; red lasts 16 cycles. en=0 in GLD -> stays GLD, load repeats.
- clr=1 during YEL at cnt_q=1 with ped_pend=1 -> cnt_clr_n=0 that cycle; next cycle state RLD, red=1, phase=00, cnt_q=0, ped_pend cleared, no later ack.
